// File: rtl/irq_ctrl_pkg.sv
// Shared types and memory-map constants for the interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    localparam int unsigned ID_W           = 4;
    localparam logic [9:0]  DEF_VEC_BASE   = 10'h3F0;
    localparam int unsigned DEF_VEC_STRIDE = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: valid flag plus index of the first set bit.
module irq_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// N-channel interrupt controller: edge capture, masking, priority request/ack/reti.
// Define IRQ_CTRL_NEST_EN to allow higher-priority channels to preempt in-service ones.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned     N_IRQ      = 4,
    parameter int unsigned     PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(DEF_VEC_BASE),
    parameter int unsigned     VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ei,
    input  logic             di,
    input  logic             ack,
    input  logic             reti,
    output logic             irq_req,
    output logic [PC_W-1:0]  vector,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    irq_state_t       state;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] irq_prev;
    logic             gie;

    logic [N_IRQ-1:0] cand;
    logic             cand_v;
    logic [ID_W-1:0]  cand_id;
    logic             is_v;
    logic [ID_W-1:0]  is_id;
    logic             winner;
    logic             take;
    logic [N_IRQ-1:0] ack_set;
    logic [N_IRQ-1:0] reti_clr;
    logic [PC_W-1:0]  vec_off;

    assign cand = pending & ~mask & {N_IRQ{gie}};

    irq_prio_enc #(.N(N_IRQ), .IW(ID_W)) u_cand_enc (
        .req   (cand),
        .valid (cand_v),
        .idx   (cand_id)
    );

    irq_prio_enc #(.N(N_IRQ), .IW(ID_W)) u_is_enc (
        .req   (in_service),
        .valid (is_v),
        .idx   (is_id)
    );

    // The lowest candidate is the only one that can beat the in-service level.
`ifdef IRQ_CTRL_NEST_EN
    assign winner = cand_v && (!is_v || (cand_id < is_id));
`else
    assign winner = cand_v && !is_v;
`endif

    always_comb begin
        take     = (state == REQ) && ack;
        ack_set  = take ? (N_IRQ'(1) << irq_id) : '0;
        reti_clr = (reti && is_v) ? (N_IRQ'(1) << is_id) : '0;
        vec_off  = PC_W'(32'(cand_id) * VEC_STRIDE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= '1;
            irq_prev   <= '0;
            gie        <= 1'b0;
        end else begin
            // A fresh edge on the acked channel survives the ack clear.
            pending    <= (pending & ~ack_set) | (irq_in & ~irq_prev);
            in_service <= (in_service & ~reti_clr) | ack_set;
            irq_prev   <= irq_in;
            if (mask_we) mask <= mask_wdata;
            if (di)      gie  <= 1'b0;
            else if (ei) gie  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
            vector  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner) begin
                        irq_req <= 1'b1;
                        irq_id  <= cand_id;
                        vector  <= VEC_BASE + vec_off;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        irq_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a per-channel behavioural model checked every cycle.
module tb_irq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         ei, di, ack, reti;
    logic         irq_req;
    logic [9:0]   vector;
    logic [3:0]   irq_id;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_IRQ      (4),
        .PC_W       (10),
        .VEC_BASE   (10'h3F0),
        .VEC_STRIDE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ei         (ei),
        .di         (di),
        .ack        (ack),
        .reti       (reti),
        .irq_req    (irq_req),
        .vector     (vector),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel bookkeeping in plain integers and bit arrays.
    bit [N-1:0] m_pend, m_mask, m_is, m_prev;
    bit         m_gie, m_req;
    int         m_id, m_vec;
    bit [N-1:0] nx_pend, nx_is;
    int         lo_is, win;

    function automatic bit may_preempt(input int ch, input int lowest_busy, input bit [N-1:0] busy);
`ifdef IRQ_CTRL_NEST_EN
        return ch < lowest_busy;
`else
        return busy == 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pend <= '0; m_mask <= '1; m_is <= '0; m_prev <= '0;
            m_gie <= 1'b0; m_req <= 1'b0; m_id <= 0; m_vec <= 0;
        end else begin
            nx_pend = m_pend;
            nx_is   = m_is;
            lo_is   = N;
            for (int i = N - 1; i >= 0; i--) if (m_is[i]) lo_is = i;
            if (m_req && ack) nx_pend[m_id] = 1'b0;
            for (int i = 0; i < N; i++) if (irq_in[i] && !m_prev[i]) nx_pend[i] = 1'b1;
            if (reti && lo_is < N) nx_is[lo_is] = 1'b0;
            if (m_req && ack) nx_is[m_id] = 1'b1;
            m_pend <= nx_pend;
            m_is   <= nx_is;
            m_prev <= irq_in;
            if (mask_we) m_mask <= mask_wdata;
            m_gie <= di ? 1'b0 : (ei ? 1'b1 : m_gie);
            if (m_req) begin
                if (ack) m_req <= 1'b0;
            end else begin
                win = -1;
                for (int i = 0; i < N; i++)
                    if (win < 0 && m_gie && m_pend[i] && !m_mask[i] && may_preempt(i, lo_is, m_is))
                        win = i;
                if (win >= 0) begin
                    m_req <= 1'b1;
                    m_id  <= win;
                    m_vec <= (32'h3F0 + win * 4) % 1024;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("model irq_req", 32'(irq_req), 32'(m_req));
            chk("model pending", 32'(pending), 32'(m_pend));
            chk("model in_service", 32'(in_service), 32'(m_is));
            if (m_req) begin
                chk("model irq_id", 32'(irq_id), 32'(m_id));
                chk("model vector", 32'(vector), 32'(m_vec));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [N-1:0] lines);
        irq_in = lines; cyc(1); irq_in = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (irq_req) ack = 1'b1;
            else if (in_service != 0) reti = 1'b1;
            cyc(1);
            ack = 1'b0; reti = 1'b0;
        end
        chk("drain idle", {irq_req, in_service}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        ei = 1'b0; di = 1'b0; ack = 1'b0; reti = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("reset irq_req", 32'(irq_req), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset in_service", 32'(in_service), 0);
        chk("reset vector", 32'(vector), 0);

        // Single channel 2 event
        mask_we = 1'b1; mask_wdata = 4'b0000; ei = 1'b1;
        cyc(1);
        mask_we = 1'b0; ei = 1'b0;
        pulse(4'b0100);
        chk("t1 pending", 32'(pending), 32'b0100);
        chk("t1 latency", 32'(irq_req), 0);
        cyc(1);
        chk("t1 irq_req", 32'(irq_req), 1);
        chk("t1 irq_id", 32'(irq_id), 2);
        chk("t1 vector", 32'(vector), 32'h3F8);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("t1 ack pending", 32'(pending), 0);
        chk("t1 ack in_service", 32'(in_service), 32'b0100);
        chk("t1 ack irq_req", 32'(irq_req), 0);
        reti = 1'b1; cyc(1); reti = 1'b0;
        chk("t1 reti", 32'(in_service), 0);

        // Two events, priority order and blocking by in_service
        pulse(4'b1010);
        cyc(1);
        chk("t2 irq_id", 32'(irq_id), 1);
        chk("t2 vector", 32'(vector), 32'h3F4);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("t2 in_service", 32'(in_service), 32'b0010);
        cyc(3);
        chk("t2 blocked", 32'(irq_req), 0);
        chk("t2 pending", 32'(pending), 32'b1000);
        reti = 1'b1; cyc(1); reti = 1'b0;
        chk("t2 reti", 32'(in_service), 0);
        cyc(1);
        chk("t2 ch3 req", 32'(irq_req), 1);
        chk("t2 ch3 vector", 32'(vector), 32'h3FC);
        drain();

        // Higher priority while servicing channel 2
        pulse(4'b0100);
        cyc(1);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("t3 in_service", 32'(in_service), 32'b0100);
        pulse(4'b0001);
        cyc(1);
`ifdef IRQ_CTRL_NEST_EN
        chk("t3 nest req", 32'(irq_req), 1);
        chk("t3 nest vector", 32'(vector), 32'h3F0);
        ack = 1'b1; reti = 1'b1; cyc(1); ack = 1'b0; reti = 1'b0;
        chk("t3 ack+reti", 32'(in_service), 32'b0001);
`else
        chk("t3 no nest req", 32'(irq_req), 0);
        chk("t3 no nest pending", 32'(pending), 32'b0001);
`endif
        drain();

        // Masked event released by a mask write
        mask_we = 1'b1; mask_wdata = 4'b0001; cyc(1); mask_we = 1'b0;
        pulse(4'b0001);
        cyc(2);
        chk("t4 masked pending", 32'(pending), 32'b0001);
        chk("t4 masked req", 32'(irq_req), 0);
        mask_we = 1'b1; mask_wdata = 4'b0000; cyc(1); mask_we = 1'b0;
        cyc(1);
        chk("t4 unmask req", 32'(irq_req), 1);
        chk("t4 unmask id", 32'(irq_id), 0);
        drain();

        // Held level gives one event; edge coincident with ack keeps pending
        irq_in = 4'b1000; cyc(20);
        chk("t5 level pending", 32'(pending), 32'b1000);
        chk("t5 level id", 32'(irq_id), 3);
        irq_in = '0; cyc(1);
        irq_in = 4'b1000; ack = 1'b1; cyc(1); ack = 1'b0; irq_in = '0;
        chk("t5 ack+edge pending", 32'(pending), 32'b1000);
        chk("t5 ack+edge in_service", 32'(in_service), 32'b1000);
        drain();

        // Reset while requesting
        pulse(4'b0010);
        cyc(1);
        chk("t6 req before reset", 32'(irq_req), 1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("t6 reset irq_req", 32'(irq_req), 0);
        chk("t6 reset pending", 32'(pending), 0);
        chk("t6 reset in_service", 32'(in_service), 0);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("t6 stray ack", 32'(in_service), 0);
        ei = 1'b1; cyc(1); ei = 1'b0;
        pulse(4'b0001);
        cyc(2);
        chk("t6 reset mask pending", 32'(pending), 32'b0001);
        chk("t6 reset mask req", 32'(irq_req), 0);

        // ei and di together leave interrupts disabled
        mask_we = 1'b1; mask_wdata = 4'b0000; ei = 1'b1; di = 1'b1;
        cyc(1);
        mask_we = 1'b0; ei = 1'b0; di = 1'b0;
        cyc(2);
        chk("t7 di wins", 32'(irq_req), 0);
        ei = 1'b1; cyc(1); ei = 1'b0;
        cyc(1);
        chk("t7 ei req", 32'(irq_req), 1);
        chk("t7 ei vector", 32'(vector), 32'h3F0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller for the 10-bit-PC CPU datapath.
- Generalises the fixed 4-line interrupt-enable encoder and constant vector registers. Adds N channels, edge capture, per-channel masking, a global enable and an ack/return handshake with the control unit.
- Supplies a request and a vector to the PC-source mux; the control unit pushes the return address onto the stack when it acks.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..16); channel 0 has the highest priority.
- PC_W, 10, width of the program-counter/vector.
- VEC_BASE, 10'h3F0, vector of channel 0.
- VEC_STRIDE, 4, address distance between consecutive channel vectors.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- irq_in  in  N_IRQ  interrupt lines, already synchronous to clk
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  N_IRQ  new mask (1 = channel masked)
- ei  in  1  set global interrupt enable
- di  in  1  clear global interrupt enable
- ack  in  1  CPU takes the pending request this cycle
- reti  in  1  CPU finished the current service routine
- irq_req  out  1  request to the CPU
- vector  out  PC_W  target PC, valid while irq_req=1
- irq_id  out  4  channel being requested
- pending  out  N_IRQ  captured, not yet acked events
- in_service  out  N_IRQ  channels currently being serviced

Behaviour:
- Reset values: irq_req=0, vector=0, irq_id=0, pending=0, in_service=0, mask=all ones, gie=0, edge-history register=0.
- Edge capture: pending[i] is set at the clock edge where irq_in[i]=1 and its previous sampled value was 0. Level-high holding lines produce one event only.
- Candidate set: pending & ~mask, qualified by gie=1. The winner is the lowest index whose priority beats every in_service bit, i.e. its index is below the lowest set in_service index. When in_service=0, any candidate qualifies.
- FSM has two states, IDLE and REQ.
  - IDLE: if a winner exists, latch irq_id, set vector = VEC_BASE + id*VEC_STRIDE (mod 2^PC_W), assert irq_req, go to REQ.
  - REQ: hold irq_req, irq_id and vector stable until ack. A request is never withdrawn, even if mask, di or a higher-priority event arrives meanwhile.
  - ack in REQ: clear pending[irq_id], set in_service[irq_id], deassert irq_req next cycle, go to IDLE.
  - ack in IDLE: ignored.
- Latency: irq_in rises and is sampled at edge t; pending is set at t; irq_req is high after edge t+1 (2-cycle minimum).
- reti clears the lowest-index set bit of in_service. reti with in_service=0 is ignored.
- Same-cycle events:
  - ack and a new edge on the same channel: pending stays 1.
  - ack and reti: both applied; reti acts on the pre-ack in_service value.
  - ei and di together: di wins.
  - mask_we: takes effect for candidate selection from the next cycle.
- gie is not altered by ack; software controls nesting through ei/di.
- reset in REQ: returns to IDLE with all state cleared; no ack is expected.

Optional Feature:
- Macro: IRQ_CTRL_NEST_EN.
- Defined: preemption as described above; a higher-priority channel may interrupt a lower one.
- Undefined: no winner is selected while in_service != 0. in_service holds at most one bit, and reti clears it.

Decomposition:
- Package irq_ctrl_pkg holds:
  - the FSM state enum (IDLE, REQ);
  - ID_W=4;
  - the default VEC_BASE/VEC_STRIDE constants shared with the memory map.
- One sub-module, irq_prio_enc: parametrised lowest-index-first priority encoder returning valid + index. It is instanced twice, once for the candidate set and once for in_service.

Test Plan:
- Reset, then mask_wdata=4'b0000, ei; pulse irq_in[2] -> irq_req=1 two cycles later, irq_id=2, vector=10'h3F8; ack -> pending=0, in_service=4'b0100.
- Pending 4'b1010 with gie=1 -> winner channel 1, vector=10'h3F4. After ack, channel 3 is not requested while in_service[1]=1. After reti, channel 3 is requested with vector=10'h3FC.
- With IRQ_CTRL_NEST_EN, servicing channel 2 and an irq_in[0] edge -> request for channel 0, vector=10'h3F0. Without the macro -> no request until reti.
- mask=4'b0001, irq_in[0] edge -> pending[0]=1, irq_req stays 0. Write mask=0 -> request follows within 1 cycle.
- irq_in[3] held high for 20 cycles -> exactly one pending event. An edge on channel 3 in the same cycle as ack of channel 3 -> pending[3] remains 1.
- reset asserted while in REQ -> next cycle irq_req=0, pending=0, in_service=0, mask=4'b1111; a later ack is ignored.
